// File: rtl/sopc4_pio_poller_pkg.sv
// Shared definitions for the PIO poller: register map, CTRL/STATUS bit
// positions and the poll sequencer state type.
package sopc4_poll_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DATA   = 2'd3;

  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_IRQ_EN_BIT      = 1;
  localparam int CTRL_CHANGE_ONLY_BIT = 2;
  localparam int CTRL_FLUSH_BIT       = 3;

  localparam int STATUS_EMPTY_BIT    = 8;
  localparam int STATUS_FULL_BIT     = 9;
  localparam int STATUS_OVERFLOW_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_CAPTURE = 2'd3
  } poll_state_t;

endpackage

// File: rtl/sopc4_pio_poller_if.sv
// Bus bundle for the poller: the CPU-facing configuration slave and the
// master port towards the PIO. The "slave" modport is the poller's view,
// the "master" modport is the view of the CPU and the PIO it talks to.
interface sopc4_pio_poller_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        cfg_address;
  logic              cfg_read;
  logic              cfg_write;
  logic [31:0]       cfg_writedata;
  logic [31:0]       cfg_readdata;
  logic [1:0]        pio_address;
  logic              pio_read;
  logic [DATA_W-1:0] pio_readdata;

  modport slave (
    input  cfg_address, cfg_read, cfg_write, cfg_writedata,
    output cfg_readdata,
    output pio_address, pio_read,
    input  pio_readdata
  );

  modport master (
    output cfg_address, cfg_read, cfg_write, cfg_writedata,
    input  cfg_readdata,
    input  pio_address, pio_read,
    output pio_readdata
  );
endinterface

// File: rtl/sopc4_poll_fifo.sv
// Small synchronous FIFO for captured samples. A push while full is only
// accepted when a pop happens in the same cycle; a pop while empty is ignored.
// Flush empties the FIFO and wins over any push or pop in the same cycle.
module sopc4_poll_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             push_data,
  output logic [DATA_W-1:0]             head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign head    = mem[rd_ptr];
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  // Sample storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; count never exceeds FIFO_DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sopc4_pio_poller.sv
// Periodic PIO poller: reads the PIO data register every PERIOD+2 cycles,
// queues (changed) samples in a FIFO and raises a level IRQ while data or
// an overflow is pending. The CPU drains samples through the DATA register.
// Optional debounce of changes: define SOPC4_PIO_POLLER_DEBOUNCE_EN.
module sopc4_pio_poller
  import sopc4_poll_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PERIOD_W   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sopc4_pio_poller_if.slave    bus,
  output logic                 irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                enable;
  logic                irq_en;
  logic                change_only;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic                overflow;
  logic [DATA_W-1:0]   prev;
  logic                prev_valid;
  logic [31:0]         read_mux;
  logic [31:0]         readdata_q;

  poll_state_t state;
  poll_state_t state_next;
  logic        load_cnt;
  logic        dec_cnt;
  logic        issue;
  logic        capture;

  logic              wr_ctrl;
  logic              wr_period;
  logic              wr_status;
  logic              flush;
  logic              pop;
  logic              push_req;
  logic              prev_load;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              unused_wdata;

  assign sample    = bus.pio_readdata;
  assign wr_ctrl   = bus.cfg_write && (bus.cfg_address == ADDR_CTRL);
  assign wr_period = bus.cfg_write && (bus.cfg_address == ADDR_PERIOD);
  assign wr_status = bus.cfg_write && (bus.cfg_address == ADDR_STATUS);
  assign flush     = wr_ctrl && bus.cfg_writedata[CTRL_FLUSH_BIT];
  assign pop       = bus.cfg_read && (bus.cfg_address == ADDR_DATA) && !empty;

  assign bus.pio_address  = 2'b00;
  assign bus.pio_read     = issue;
  assign bus.cfg_readdata = readdata_q;
  assign unused_wdata     = ^bus.cfg_writedata[31:17];

  // CTRL and PERIOD registers; flush is a strobe and is never stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      change_only <= 1'b0;
      period      <= '0;
    end else begin
      if (wr_ctrl) begin
        enable      <= bus.cfg_writedata[CTRL_ENABLE_BIT];
        irq_en      <= bus.cfg_writedata[CTRL_IRQ_EN_BIT];
        change_only <= bus.cfg_writedata[CTRL_CHANGE_ONLY_BIT];
      end
      if (wr_period) begin
        period <= bus.cfg_writedata[PERIOD_W-1:0];
      end
    end
  end

  // Poll sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state: WAIT lasts PERIOD cycles, so a zero PERIOD skips it entirely.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_next = (period == '0) ? ST_ISSUE : ST_WAIT;
        ST_WAIT:    if (counter <= PERIOD_W'(1)) state_next = ST_ISSUE;
        ST_ISSUE:   state_next = ST_CAPTURE;
        ST_CAPTURE: state_next = (period == '0) ? ST_ISSUE : ST_WAIT;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Sequencer outputs; a capture while disabling is dropped.
  always_comb begin
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    issue    = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE:    load_cnt = enable;
      ST_WAIT:    dec_cnt  = 1'b1;
      ST_ISSUE:   issue    = 1'b1;
      ST_CAPTURE: begin
        capture  = enable;
        load_cnt = 1'b1;
      end
      default: ;
    endcase
  end

  // Interval counter; PERIOD is sampled only at reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
    end else if (load_cnt) begin
      counter <= period;
    end else if (dec_cnt && counter != '0) begin
      counter <= counter - 1'b1;
    end
  end

`ifdef SOPC4_PIO_POLLER_DEBOUNCE_EN
  logic [DATA_W-1:0] cand;
  logic              cand_valid;
  logic              differs;

  // A change counts only once the same new value is seen in two captures.
  always_comb begin
    differs   = prev_valid && (sample != prev);
    push_req  = capture && (!change_only || !prev_valid ||
                            (differs && cand_valid && (cand == sample)));
    prev_load = push_req;
  end

  // Candidate tracking; a different new value restarts qualification.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand       <= '0;
      cand_valid <= 1'b0;
    end else if (!enable) begin
      cand_valid <= 1'b0;
    end else if (capture) begin
      if (push_req || !differs) begin
        cand_valid <= 1'b0;
      end else begin
        cand       <= sample;
        cand_valid <= 1'b1;
      end
    end
  end
`else
  // Single-sample change test; prev follows every capture.
  always_comb begin
    push_req  = capture && (!change_only || !prev_valid || (sample != prev));
    prev_load = capture;
  end
`endif

  // Last captured value; forgotten whenever polling is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (!enable) begin
      prev_valid <= 1'b0;
    end else if (prev_load) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

  sopc4_poll_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req),
    .pop       (pop),
    .flush     (flush),
    .push_data (sample),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Sticky overflow: a lost sample beats a simultaneous software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push_req && full && !pop && !flush) begin
      overflow <= 1'b1;
    end else if (wr_status && bus.cfg_writedata[STATUS_OVERFLOW_BIT]) begin
      overflow <= 1'b0;
    end
  end

  // Register read multiplexer; an empty DATA read returns zero.
  always_comb begin
    read_mux = '0;
    case (bus.cfg_address)
      ADDR_CTRL: begin
        read_mux[CTRL_ENABLE_BIT]      = enable;
        read_mux[CTRL_IRQ_EN_BIT]      = irq_en;
        read_mux[CTRL_CHANGE_ONLY_BIT] = change_only;
      end
      ADDR_PERIOD: read_mux[PERIOD_W-1:0] = period;
      ADDR_STATUS: begin
        read_mux[7:0]                 = 8'(count);
        read_mux[STATUS_EMPTY_BIT]    = empty;
        read_mux[STATUS_FULL_BIT]     = full;
        read_mux[STATUS_OVERFLOW_BIT] = overflow;
      end
      ADDR_DATA: if (!empty) read_mux[DATA_W-1:0] = head;
      default: ;
    endcase
  end

  // Read data register, updated only when the CPU reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          readdata_q <= '0;
    else if (bus.cfg_read) readdata_q <= read_mux;
  end

  // Registered interrupt level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= irq_en && (!empty || overflow);
  end
endmodule

// File: tb/tb_sopc4_pio_poller.sv
// Directed testbench for sopc4_pio_poller with a latency-1 PIO model.
// Samples returned by the PIO come from pio_seq (last value repeats).
module tb_sopc4_pio_poller;
  import sopc4_poll_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        irq;
  logic [31:0] pio_rd_q = '0;
  logic [31:0] pio_seq [$];
  int          checks = 0;
  int          errors = 0;

  sopc4_pio_poller_if #(.DATA_W(32)) bus ();

  sopc4_pio_poller #(
    .DATA_W     (32),
    .PERIOD_W   (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .irq     (irq)
  );

  assign bus.pio_readdata = pio_rd_q;

  always #5 clk = ~clk;

  // PIO data register with read latency 1
  always @(posedge clk) begin
    if (bus.pio_read && pio_seq.size() > 0) pio_rd_q <= pio_seq.pop_front();
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cfg_address   = a;
    bus.cfg_writedata = d;
    bus.cfg_write     = 1'b1;
    @(negedge clk);
    bus.cfg_write     = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cfg_address = a;
    bus.cfg_read    = 1'b1;
    @(negedge clk);
    bus.cfg_read    = 1'b0;
    d = bus.cfg_readdata;
  endtask

  task automatic wait_pio_read(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.pio_read && cycles < 200);
    checks++;
    if (bus.pio_read !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pio_read_timeout: pio_read=%b after %0d cycles, required 1", bus.pio_read, cycles);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int cyc;
    pio_seq.push_back(32'h77);
    cfg_write(ADDR_PERIOD, 32'd3);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_pio_read(cyc);
    repeat (2) @(negedge clk);
    wait_pio_read(cyc);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.pio_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_pio_read: got %b required 0", bus.pio_read); end
    checks++;
    if (bus.pio_address !== 2'b00) begin errors++; $display("[TB] FAIL rst_pio_address: got %h required 0", bus.pio_address); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq: got %b required 0", irq); end
    checks++;
    if (bus.cfg_readdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_readdata: got %h required 0", bus.cfg_readdata); end
    checks++;
    if (dut.state !== ST_IDLE) begin errors++; $display("[TB] FAIL rst_state: got %0d required IDLE", dut.state); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cfg_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h100) begin errors++; $display("[TB] FAIL rst_status: got %h required 00000100", rd); end
    cfg_read(ADDR_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_ctrl: got %h required 0", rd); end
    cfg_read(ADDR_PERIOD, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_period: got %h required 0", rd); end
  endtask

  task automatic test_poll();
    logic [31:0] rd;
    int cyc;
    pio_seq = {32'hA5, 32'hA5, 32'hA5};
    cfg_write(ADDR_PERIOD, 32'd3);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_pio_read(cyc);
    for (int i = 0; i < 2; i++) begin
      wait_pio_read(cyc);
      checks++;
      if (cyc != 5) begin errors++; $display("[TB] FAIL poll_interval%0d: got %0d cycles required 5", i, cyc); end
    end
    repeat (2) @(negedge clk);
    cfg_write(ADDR_CTRL, 32'h0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL poll_irq_masked: got %b required 0", irq); end
    cfg_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h3) begin errors++; $display("[TB] FAIL poll_status: got %h required 00000003", rd); end
    for (int i = 0; i < 3; i++) begin
      cfg_read(ADDR_DATA, rd);
      checks++;
      if (rd !== 32'hA5) begin errors++; $display("[TB] FAIL poll_data%0d: got %h required 000000a5", i, rd); end
    end
    cfg_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL poll_empty_data: got %h required 0", rd); end
    cfg_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h100) begin errors++; $display("[TB] FAIL poll_empty_status: got %h required 00000100", rd); end
  endtask

  task automatic test_period_zero();
    logic [31:0] rd;
    int cyc;
    cfg_write(ADDR_PERIOD, 32'd0);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_pio_read(cyc);
    wait_pio_read(cyc);
    checks++;
    if (cyc != 2) begin errors++; $display("[TB] FAIL p0_interval: got %0d cycles required 2", cyc); end
    cfg_write(ADDR_CTRL, 32'h8);
    cfg_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h100) begin errors++; $display("[TB] FAIL p0_flush_status: got %h required 00000100", rd); end
    cfg_read(ADDR_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL p0_flush_ctrl: got %h required 0", rd); end
    cfg_write(ADDR_PERIOD, 32'd3);
  endtask

  task automatic test_change_only();
    logic [31:0] rd;
    logic [31:0] exp_vals [3] = '{32'h1, 32'h2, 32'h1};
    int cyc;
    pio_seq = {32'h1, 32'h1, 32'h2, 32'h2, 32'h1};
    cfg_write(ADDR_CTRL, 32'h5);
    repeat (5) wait_pio_read(cyc);
    repeat (2) @(negedge clk);
    cfg_write(ADDR_CTRL, 32'h4);
    cfg_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h3) begin errors++; $display("[TB] FAIL chg_status: got %h required 00000003", rd); end
    for (int i = 0; i < 3; i++) begin
      cfg_read(ADDR_DATA, rd);
      checks++;
      if (rd !== exp_vals[i]) begin errors++; $display("[TB] FAIL chg_data%0d: got %h required %h", i, rd, exp_vals[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int cyc;
    pio_seq.delete();
    for (int i = 1; i <= 10; i++) pio_seq.push_back(32'(i));
    cfg_write(ADDR_CTRL, 32'h7);
    repeat (10) wait_pio_read(cyc);
    repeat (2) @(negedge clk);
    cfg_write(ADDR_CTRL, 32'h6);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL ovf_irq: got %b required 1", irq); end
    cfg_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h10208) begin errors++; $display("[TB] FAIL ovf_status: got %h required 00010208", rd); end
    cfg_write(ADDR_STATUS, 32'h10000);
    cfg_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h208) begin errors++; $display("[TB] FAIL ovf_cleared_status: got %h required 00000208", rd); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL ovf_irq_pending: got %b required 1", irq); end
    for (int i = 1; i <= 8; i++) begin
      cfg_read(ADDR_DATA, rd);
      checks++;
      if (rd !== 32'(i)) begin errors++; $display("[TB] FAIL ovf_data%0d: got %h required %h", i, rd, 32'(i)); end
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ovf_irq_drained: got %b required 0", irq); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] rd;
    int cyc;
    pio_seq.delete();
    for (int i = 0; i < 9; i++) pio_seq.push_back(32'h11 + 32'(i));
    cfg_write(ADDR_CTRL, 32'h5);
    repeat (9) wait_pio_read(cyc);
    @(negedge clk);
    bus.cfg_address = ADDR_DATA;
    bus.cfg_read    = 1'b1;
    @(negedge clk);
    bus.cfg_read    = 1'b0;
    rd = bus.cfg_readdata;
    checks++;
    if (rd !== 32'h11) begin errors++; $display("[TB] FAIL pp_head: got %h required 00000011", rd); end
    cfg_write(ADDR_CTRL, 32'h4);
    cfg_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h208) begin errors++; $display("[TB] FAIL pp_status: got %h required 00000208", rd); end
    for (int i = 0; i < 8; i++) begin
      cfg_read(ADDR_DATA, rd);
      checks++;
      if (rd !== 32'h12 + 32'(i)) begin errors++; $display("[TB] FAIL pp_data%0d: got %h required %h", i, rd, 32'h12 + 32'(i)); end
    end
  endtask

`ifdef SOPC4_PIO_POLLER_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] rd;
    int cyc;
    pio_seq = {32'h0, 32'h5, 32'h6, 32'h6};
    cfg_write(ADDR_CTRL, 32'h5);
    repeat (4) wait_pio_read(cyc);
    repeat (2) @(negedge clk);
    cfg_write(ADDR_CTRL, 32'h4);
    cfg_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("[TB] FAIL deb_status: got %h required 00000002", rd); end
    cfg_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL deb_data0: got %h required 0", rd); end
    cfg_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'h6) begin errors++; $display("[TB] FAIL deb_data1: got %h required 00000006", rd); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n           = 1'b0;
    bus.cfg_address   = '0;
    bus.cfg_read      = 1'b0;
    bus.cfg_write     = 1'b0;
    bus.cfg_writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_poll();
    test_period_zero();
    test_change_only();
    test_overflow();
    test_push_pop_full();
`ifdef SOPC4_PIO_POLLER_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
